// File: rtl/cordic_wrapper_pkg.sv
// Shared types and constants for the folded CORDIC engine: function select,
// FSM states, binary-angle atan table, quadrant angles and gain-compensation shifts.
package cordic_wrapper_pkg;

  typedef enum logic {
    ROTATE = 1'b0,
    VECTOR = 1'b1
  } cordic_func;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_GAIN = 2'd2,
    S_DONE = 2'd3
  } cordic_state;

  localparam int ITER_IDX_W = 5;

  // atan(2^-i) in 32-bit binary angle units, 2^31 == pi
  localparam logic [31:0] ATAN_TAB [32] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  localparam logic [31:0] ANGLE_PI_HALF     = 32'h4000_0000;
  localparam logic [31:0] ANGLE_NEG_PI_HALF = 32'hC000_0000;

  // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9
  localparam int GAIN_SH_ADD0 = 1;
  localparam int GAIN_SH_ADD1 = 3;
  localparam int GAIN_SH_SUB0 = 6;
  localparam int GAIN_SH_SUB1 = 9;

endpackage

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation; the engine folds it over time.
module cordic_microrot
  import cordic_wrapper_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W+1:0] i_x,
  input  logic signed [DATA_W+1:0] i_y,
  input  logic signed [DATA_W-1:0] i_z,
  input  logic [ITER_IDX_W-1:0]    i_idx,
  input  cordic_func               i_func,
  output logic signed [DATA_W+1:0] o_x,
  output logic signed [DATA_W+1:0] o_y,
  output logic signed [DATA_W-1:0] o_z
);

  logic signed [DATA_W+1:0] x_sh;
  logic signed [DATA_W+1:0] y_sh;
  logic signed [DATA_W-1:0] atan_i;
  logic                     d_pos;

  always_comb begin
    x_sh   = i_x >>> i_idx;
    y_sh   = i_y >>> i_idx;
    atan_i = DATA_W'(ATAN_TAB[i_idx] >> (32 - DATA_W));
    // rotate drives z to zero, vector drives y to zero
    d_pos  = (i_func == ROTATE) ? ~i_z[DATA_W-1] : i_y[DATA_W+1];
    if (d_pos) begin
      o_x = i_x - y_sh;
      o_y = i_y + x_sh;
      o_z = i_z - atan_i;
    end else begin
      o_x = i_x + y_sh;
      o_y = i_y - x_sh;
      o_z = i_z + atan_i;
    end
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// Folded CORDIC engine, rotation/vectoring over +-pi with valid/ready on both sides.
// Define CORDIC_GAIN_COMP_EN to add the GAIN state that removes the CORDIC gain K.
module cordic_iter_engine
  import cordic_wrapper_pkg::*;
#(
  parameter int DATA_W             = 16,
  parameter int NUM_MICRO_ROTATION = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  cordic_func               i_func,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_y,
  input  logic signed [DATA_W-1:0] i_z,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DATA_W-1:0] o_x,
  output logic signed [DATA_W-1:0] o_y,
  output logic signed [DATA_W-1:0] o_z
);

  localparam int XW = DATA_W + 2;
  localparam logic signed [DATA_W-1:0] Z_PI_HALF     = DATA_W'(ANGLE_PI_HALF >> (32 - DATA_W));
  localparam logic signed [DATA_W-1:0] Z_NEG_PI_HALF = DATA_W'(ANGLE_NEG_PI_HALF >> (32 - DATA_W));
  localparam logic [ITER_IDX_W-1:0]    LAST_IDX      = ITER_IDX_W'(NUM_MICRO_ROTATION);

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [XW-1:0] v);
    if ((&v[XW-1:DATA_W-1]) || (~|v[XW-1:DATA_W-1])) return v[DATA_W-1:0];
    else if (v[XW-1]) return {1'b1, {(DATA_W-1){1'b0}}};
    else return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  function automatic logic signed [XW-1:0] gain_comp(input logic signed [XW-1:0] v);
    return (v >>> GAIN_SH_ADD0) + (v >>> GAIN_SH_ADD1) - (v >>> GAIN_SH_SUB0) - (v >>> GAIN_SH_SUB1);
  endfunction
`endif

  cordic_state              state_q, state_d;
  logic [ITER_IDX_W-1:0]    cnt_q, cnt_d;
  cordic_func               func_q, func_d;
  logic signed [XW-1:0]     x_q, x_d, y_q, y_d;
  logic signed [DATA_W-1:0] z_q, z_d;
  logic signed [DATA_W-1:0] o_x_q, o_x_d, o_y_q, o_y_d, o_z_q, o_z_d;
  logic                     o_valid_q, o_valid_d, o_ready_q, o_ready_d;

  logic signed [XW-1:0]     x_ext, y_ext, mr_x, mr_y;
  logic signed [DATA_W-1:0] mr_z;

  assign x_ext = {{2{i_x[DATA_W-1]}}, i_x};
  assign y_ext = {{2{i_y[DATA_W-1]}}, i_y};

  cordic_microrot #(.DATA_W(DATA_W)) u_microrot (
    .i_x    (x_q),
    .i_y    (y_q),
    .i_z    (z_q),
    .i_idx  (cnt_q),
    .i_func (func_q),
    .o_x    (mr_x),
    .o_y    (mr_y),
    .o_z    (mr_z)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func_d    = func_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    o_x_d     = o_x_q;
    o_y_d     = o_y_q;
    o_z_d     = o_z_q;
    o_valid_d = o_valid_q;
    o_ready_d = o_ready_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          func_d    = i_func;
          cnt_d     = '0;
          x_d       = x_ext;
          y_d       = y_ext;
          z_d       = i_z;
          // quadrant pre-rotation keeps the iterations inside their +-99.9 deg reach
          if (i_func == ROTATE) begin
            if (i_z > Z_PI_HALF) begin
              x_d = -y_ext;
              y_d = x_ext;
              z_d = i_z - Z_PI_HALF;
            end else if (i_z < Z_NEG_PI_HALF) begin
              x_d = y_ext;
              y_d = -x_ext;
              z_d = i_z + Z_PI_HALF;
            end
          end else if (i_x[DATA_W-1]) begin
            if (!i_y[DATA_W-1]) begin
              x_d = y_ext;
              y_d = -x_ext;
              z_d = i_z + Z_PI_HALF;
            end else begin
              x_d = -y_ext;
              y_d = x_ext;
              z_d = i_z - Z_PI_HALF;
            end
          end
          o_ready_d = 1'b0;
          state_d   = S_ITER;
        end
      end
      S_ITER: begin
        // cnt 0..N-1 rotate; the extra cnt==N cycle hands the vector to the output stage
        if (cnt_q == LAST_IDX) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d   = S_GAIN;
`else
          o_x_d     = sat(x_q);
          o_y_d     = sat(y_q);
          o_z_d     = z_q;
          o_valid_d = 1'b1;
          state_d   = S_DONE;
`endif
        end else begin
          x_d   = mr_x;
          y_d   = mr_y;
          z_d   = mr_z;
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_GAIN: begin
        o_x_d     = sat(gain_comp(x_q));
        o_y_d     = sat(gain_comp(y_q));
        o_z_d     = z_q;
        o_valid_d = 1'b1;
        state_d   = S_DONE;
      end
`endif
      S_DONE: begin
        if (i_ready) begin
          o_valid_d = 1'b0;
          o_ready_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        o_valid_d = 1'b0;
        o_ready_d = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      o_x_q     <= '0;
      o_y_q     <= '0;
      o_z_q     <= '0;
      o_valid_q <= 1'b0;
      o_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_x_q     <= o_x_d;
      o_y_q     <= o_y_d;
      o_z_q     <= o_z_d;
      o_valid_q <= o_valid_d;
      o_ready_q <= o_ready_d;
    end
  end

  // working datapath needs no reset: it is always loaded on accept
  always_ff @(posedge i_clk) begin
    func_q <= func_d;
    x_q    <= x_d;
    y_q    <= y_d;
    z_q    <= z_d;
  end

  assign o_ready = o_ready_q;
  assign o_valid = o_valid_q;
  assign o_x     = o_x_q;
  assign o_y     = o_y_q;
  assign o_z     = o_z_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine (DATA_W=16, 12 micro-rotations); expectations
// follow CORDIC_GAIN_COMP_EN so the same file covers both builds.
module tb_cordic_iter_engine;
  import cordic_wrapper_pkg::*;

  localparam int N = 12;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic               i_clk   = 1'b0;
  logic               i_rst   = 1'b0;
  logic               i_valid = 1'b0;
  logic               i_ready = 1'b1;
  cordic_func         i_func  = ROTATE;
  logic signed [15:0] i_x = '0, i_y = '0, i_z = '0;
  logic               o_ready, o_valid;
  logic signed [15:0] o_x, o_y, o_z;

  int n_run  = 0;
  int n_fail = 0;
  int lat;

  always #5 i_clk = ~i_clk;

  cordic_iter_engine #(.DATA_W(16), .NUM_MICRO_ROTATION(N)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_func  (i_func),
    .i_x     (i_x),
    .i_y     (i_y),
    .i_z     (i_z),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_x     (o_x),
    .o_y     (o_y),
    .o_z     (o_z)
  );

  // true-scale magnitude as seen at the outputs of this build
  function automatic int scale_k(input int v);
`ifdef CORDIC_GAIN_COMP_EN
    return v;
`else
    return (v * 16468) / 10000;
`endif
  endfunction

  function automatic int tol_of(input int e);
    return ((e < 0) ? -e : e) / 500 + 4;
  endfunction

  task automatic check(input string tag, input int got, input int exp, input int tol);
    int diff;
    n_run++;
    diff = (got > exp) ? got - exp : exp - got;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+-%0d)", tag, got, exp, tol);
    end
  endtask

  task automatic start_op(input cordic_func f, input int x, input int y, input int z);
    i_func  = f;
    i_x     = 16'(x);
    i_y     = 16'(y);
    i_z     = 16'(z);
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_func  = (f == ROTATE) ? VECTOR : ROTATE;
    i_x     = 16'sh5a5a;
    i_y     = -16'sh3c3c;
    i_z     = 16'sh7001;
  endtask

  task automatic wait_done(input string tag);
    lat = 0;
    while (!o_valid && lat < 200) begin
      @(posedge i_clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, LAT, 0);
  endtask

  task automatic consume(input string tag);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    check({tag, "_vld_drop"}, o_valid, 0, 0);
    check({tag, "_rdy_rise"}, o_ready, 1, 0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", o_valid, 0, 0);
    check("rst_x", o_x, 0, 0);
    check("rst_y", o_y, 0, 0);
    check("rst_z", o_z, 0, 0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("rst_ready", o_ready, 1, 0);
    check("rst_valid_after", o_valid, 0, 0);

    // rotate (10000,0) by pi/4
    start_op(ROTATE, 10000, 0, 8192);
    check("rot45_busy", o_ready, 0, 0);
    wait_done("rot45");
    check("rot45_x", o_x, scale_k(7071), tol_of(scale_k(7071)));
    check("rot45_y", o_y, scale_k(7071), tol_of(scale_k(7071)));
    check("rot45_z", o_z, 0, 4);
    consume("rot45");

    // vectoring 3-4-5
    start_op(VECTOR, 3000, 4000, 0);
    wait_done("vec345");
    check("vec345_x", o_x, scale_k(5000), tol_of(scale_k(5000)));
    check("vec345_y", o_y, 0, 4);
    check("vec345_z", o_z, 9672, tol_of(9672));
    consume("vec345");

    // rotate by -3pi/4 through pre-rotation
    start_op(ROTATE, 10000, 0, -24576);
    wait_done("rotm135");
    check("rotm135_x", o_x, scale_k(-7071), tol_of(scale_k(-7071)));
    check("rotm135_y", o_y, scale_k(-7071), tol_of(scale_k(-7071)));
    check("rotm135_z", o_z, 0, 4);
    consume("rotm135");

    // vectoring in third quadrant
    start_op(VECTOR, -3000, -4000, 0);
    wait_done("vecq3");
    check("vecq3_x", o_x, scale_k(5000), tol_of(scale_k(5000)));
    check("vecq3_y", o_y, 0, 8);
    check("vecq3_z", o_z, -23096, tol_of(-23096));
    consume("vecq3");

    // magnitude beyond full scale saturates
    start_op(VECTOR, 32767, 32767, 0);
    wait_done("vecsat");
    check("vecsat_x", o_x, 32767, 0);
    check("vecsat_z", o_z, 8192, tol_of(8192));
    consume("vecsat");

    // back-pressure: DONE held for 20 cycles
    i_ready = 1'b0;
    start_op(VECTOR, 3000, 4000, 0);
    wait_done("bp");
    for (int k = 0; k < 20; k++) begin
      @(posedge i_clk); #1;
      check("bp_valid", o_valid, 1, 0);
      check("bp_ready", o_ready, 0, 0);
      check("bp_x", o_x, scale_k(5000), tol_of(scale_k(5000)));
      check("bp_z", o_z, 9672, tol_of(9672));
    end
    consume("bp");

    // asynchronous reset in the middle of ITER
    start_op(ROTATE, 10000, 0, 8192);
    repeat (5) begin
      @(posedge i_clk); #1;
    end
    #2 i_rst = 1'b0;
    #1;
    check("arst_valid", o_valid, 0, 0);
    check("arst_x", o_x, 0, 0);
    check("arst_y", o_y, 0, 0);
    check("arst_z", o_z, 0, 0);
    #2 i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("arst_ready", o_ready, 1, 0);
    check("arst_valid_after", o_valid, 0, 0);

    // next operation after the abort completes normally
    start_op(ROTATE, 10000, 0, 8192);
    wait_done("again");
    check("again_x", o_x, scale_k(7071), tol_of(scale_k(7071)));
    check("again_y", o_y, scale_k(7071), tol_of(scale_k(7071)));
    check("again_z", o_z, 0, 4);
    consume("again");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
